conv_layer_host: RTL and testbench

Host-side responder for the CNN convolution engine's memory protocol. It holds the 64x64 image ROM that the engine reads through `iaddr`/`idata`. It also holds the five layer memories the engine writes and reads through `cwr`/`crd`/`csel`, and it sequences the `ready`/`busy` start handshake. After the engine finishes, a dump port exposes every memory word for checking or for downstream consumers.

---
 rtl/conv_layer_host.sv | 216 +++++++++++++++++++++
 tb/tb_conv_layer_host.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_host.sv
// Host-side responder for the CNN convolution engine: image ROM, five layer banks,
// ready/busy start handshake and a post-run dump port.
module conv_layer_host #(
    parameter int unsigned IMG_WORDS = 4096,
    parameter int unsigned L0_WORDS  = 4096,
    parameter int unsigned L1_WORDS  = 1024,
    parameter int unsigned L2_WORDS  = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [11:0] load_addr,
    input  logic [19:0] load_data,
    input  logic        start,
    output logic        ready,
    input  logic        busy,
    input  logic [11:0] iaddr,
    output logic [19:0] idata,
    input  logic        cwr,
    input  logic [11:0] caddr_wr,
    input  logic [19:0] cdata_wr,
    input  logic        crd,
    input  logic [11:0] caddr_rd,
    output logic [19:0] cdata_rd,
    input  logic [2:0]  csel,
    input  logic [2:0]  dump_sel,
    input  logic [11:0] dump_addr,
    output logic [19:0] dump_data,
    output logic        done,
    output logic        err,
    output logic [13:0] wr_count
);

    localparam int IMG_AW = $clog2(IMG_WORDS);
    localparam int L0_AW  = $clog2(L0_WORDS);
    localparam int L1_AW  = $clog2(L1_WORDS);
    localparam int L2_AW  = $clog2(L2_WORDS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [13:0] wr_count_q, wr_count_d;
    logic [19:0] idata_q, idata_d;
    logic [19:0] cdata_q, cdata_d;
    logic [19:0] dump_q, dump_d;

    logic [19:0] img_mem [IMG_WORDS];
    logic [19:0] l0a_mem [L0_WORDS];
    logic [19:0] l0b_mem [L0_WORDS];
    logic [19:0] l1a_mem [L1_WORDS];
    logic [19:0] l1b_mem [L1_WORDS];
    logic [19:0] l2_mem  [L2_WORDS];

    logic idle_like_s, start_go_s, load_go_s, wr_ok_s, rd_ok_s, err_evt_s;
    logic [19:0] layer_word_s, dump_word_s;

    // Select 000 is the image; 001-101 are the layer banks; 110/111 are never valid.
    function automatic logic sel_ok(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            3'd0:       sel_ok = (32'(addr) < IMG_WORDS);
            3'd1, 3'd2: sel_ok = (32'(addr) < L0_WORDS);
            3'd3, 3'd4: sel_ok = (32'(addr) < L1_WORDS);
            3'd5:       sel_ok = (32'(addr) < L2_WORDS);
            default:    sel_ok = 1'b0;
        endcase
    endfunction

    assign idle_like_s = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_go_s  = start && idle_like_s;
    assign load_go_s   = load_en && idle_like_s && (32'(load_addr) < IMG_WORDS);
    assign wr_ok_s     = cwr && (csel != 3'd0) && sel_ok(csel, caddr_wr);
    assign rd_ok_s     = crd && (csel != 3'd0) && sel_ok(csel, caddr_rd);
    assign err_evt_s   = (load_en && !idle_like_s) || (cwr && !wr_ok_s) || (crd && !rd_ok_s)
                       || ((cwr || crd) && (state_q != S_RUN));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the start handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_REQ : S_IDLE;
            S_REQ:   state_d = busy ? S_RUN : S_REQ;
            S_RUN:   state_d = busy ? S_RUN : S_DONE;
            S_DONE:  state_d = start ? S_REQ : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they change on the same edge as the state.
    always_comb begin
        ready_d = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_REQ:   ready_d = 1'b1;
            S_DONE:  done_d  = 1'b1;
            default: begin
                ready_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Combinational read muxes for the layer read port and the dump port.
    always_comb begin
        layer_word_s = 20'd0;
        dump_word_s  = 20'd0;
        case (csel)
            3'd1:    layer_word_s = l0a_mem[caddr_rd[L0_AW-1:0]];
            3'd2:    layer_word_s = l0b_mem[caddr_rd[L0_AW-1:0]];
            3'd3:    layer_word_s = l1a_mem[caddr_rd[L1_AW-1:0]];
            3'd4:    layer_word_s = l1b_mem[caddr_rd[L1_AW-1:0]];
            3'd5:    layer_word_s = l2_mem[caddr_rd[L2_AW-1:0]];
            default: layer_word_s = 20'd0;
        endcase
        case (dump_sel)
            3'd0:    dump_word_s = img_mem[dump_addr[IMG_AW-1:0]];
            3'd1:    dump_word_s = l0a_mem[dump_addr[L0_AW-1:0]];
            3'd2:    dump_word_s = l0b_mem[dump_addr[L0_AW-1:0]];
            3'd3:    dump_word_s = l1a_mem[dump_addr[L1_AW-1:0]];
            3'd4:    dump_word_s = l1b_mem[dump_addr[L1_AW-1:0]];
            3'd5:    dump_word_s = l2_mem[dump_addr[L2_AW-1:0]];
            default: dump_word_s = 20'd0;
        endcase
    end

    // Datapath next-state: read ports, sticky error and saturating write counter.
    always_comb begin
        idata_d = 20'd0;
        if (32'(iaddr) < IMG_WORDS) begin
            idata_d = img_mem[iaddr[IMG_AW-1:0]];
        end else begin
            idata_d = 20'd0;
        end

        cdata_d = cdata_q;
        if (rd_ok_s) begin
            cdata_d = layer_word_s;
        end else if (crd) begin
            cdata_d = 20'd0;
        end else begin
            cdata_d = cdata_q;
        end

        if (idle_like_s && sel_ok(dump_sel, dump_addr)) begin
            dump_d = dump_word_s;
        end else begin
            dump_d = 20'd0;
        end

        err_d      = (start_go_s ? 1'b0 : err_q) | err_evt_s;
        wr_count_d = start_go_s ? 14'd0 : wr_count_q;
        if (wr_ok_s && (wr_count_d != 14'h3FFF)) begin
            wr_count_d = wr_count_d + 14'd1;
        end else begin
            wr_count_d = wr_count_d;
        end
    end

    // Output and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= 14'd0;
            idata_q    <= 20'd0;
            cdata_q    <= 20'd0;
            dump_q     <= 20'd0;
        end else begin
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            idata_q    <= idata_d;
            cdata_q    <= cdata_d;
            dump_q     <= dump_d;
        end
    end

    // Memory writes; arrays keep their contents across reset. Reads above see the old word.
    always_ff @(posedge clk) begin
        if (load_go_s) begin
            img_mem[load_addr[IMG_AW-1:0]] <= load_data;
        end
        if (wr_ok_s) begin
            case (csel)
                3'd1:    l0a_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
                3'd2:    l0b_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
                3'd3:    l1a_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
                3'd4:    l1b_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
                3'd5:    l2_mem[caddr_wr[L2_AW-1:0]]  <= cdata_wr;
                default: ;
            endcase
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wr_count  = wr_count_q;
    assign idata     = idata_q;
    assign cdata_rd  = cdata_q;
    assign dump_data = dump_q;

endmodule

// File: tb/tb_conv_layer_host.sv
// Directed self-checking bench for conv_layer_host: load, handshake, bank routing,
// bounds, read-before-write and reset retention.
module tb_conv_layer_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [11:0] load_addr;
    logic [19:0] load_data;
    logic        start;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic [2:0]  dump_sel;
    logic [11:0] dump_addr;
    logic [19:0] dump_data;
    logic        done;
    logic        err;
    logic [13:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;

    conv_layer_host dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
        .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = 12'd0; load_data = 20'd0;
        start = 1'b0; busy = 1'b0; iaddr = 12'd0;
        cwr = 1'b0; caddr_wr = 12'd0; cdata_wr = 20'd0;
        crd = 1'b0; caddr_rd = 12'd0; csel = 3'd0;
        dump_sel = 3'd0; dump_addr = 12'd0;
        step(); step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_idata", 32'(idata), 32'd0);
        chk("rst_cdata", 32'(cdata_rd), 32'd0);
        chk("rst_dump", 32'(dump_data), 32'd0);
        reset = 1'b0;
        step();

        // Image load and readback.
        load_en = 1'b1; load_addr = 12'd5; load_data = 20'h0ABCD;
        step();
        load_en = 1'b0; iaddr = 12'd5; dump_sel = 3'd0; dump_addr = 12'd5;
        step();
        chk("idata_load", 32'(idata), 32'h0ABCD);
        chk("ready_idle", 32'(ready), 32'd0);
        chk("dump_img_idle", 32'(dump_data), 32'h0ABCD);
        chk("err_idle", 32'(err), 32'd0);

        // Handshake.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ready_rise", 32'(ready), 32'd1);
        step(); step(); step();
        chk("ready_hold", 32'(ready), 32'd1);
        chk("dump_req_zero", 32'(dump_data), 32'd0);
        busy = 1'b1;
        step();
        chk("ready_fall", 32'(ready), 32'd0);
        step();
        chk("dump_run_zero", 32'(dump_data), 32'd0);

        // Bank routing.
        cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd7; cdata_wr = 20'h00011;
        step();
        csel = 3'd3; cdata_wr = 20'h00022;
        step();
        cwr = 1'b0; crd = 1'b1; csel = 3'd1; caddr_rd = 12'd7;
        step();
        chk("rd_bank1", 32'(cdata_rd), 32'h00011);
        csel = 3'd3;
        step();
        chk("rd_bank3", 32'(cdata_rd), 32'h00022);
        chk("wr_count_2", 32'(wr_count), 32'd2);
        chk("err_run_clean", 32'(err), 32'd0);
        crd = 1'b0; csel = 3'd1;
        step();
        chk("cdata_hold", 32'(cdata_rd), 32'h00022);

        // Bounds.
        cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd1024; cdata_wr = 20'h00077;
        step();
        chk("err_oob_wr", 32'(err), 32'd1);
        chk("wr_count_oob", 32'(wr_count), 32'd2);
        csel = 3'd6; caddr_wr = 12'd0;
        step();
        chk("wr_count_badsel", 32'(wr_count), 32'd2);
        csel = 3'd5; caddr_wr = 12'd2048;
        step();
        chk("wr_count_l2_oob", 32'(wr_count), 32'd2);
        cwr = 1'b0; crd = 1'b1; csel = 3'd3; caddr_rd = 12'd7;
        step();
        chk("rd_bank3_intact", 32'(cdata_rd), 32'h00022);
        csel = 3'd6;
        step();
        chk("rd_badsel_zero", 32'(cdata_rd), 32'd0);

        // Read-before-write on bank 101.
        crd = 1'b0; cwr = 1'b1; csel = 3'd5; caddr_wr = 12'd3; cdata_wr = 20'h00005;
        step();
        cdata_wr = 20'h00009; crd = 1'b1; caddr_rd = 12'd3;
        step();
        chk("rbw_old", 32'(cdata_rd), 32'h00005);
        cwr = 1'b0;
        step();
        chk("rbw_new", 32'(cdata_rd), 32'h00009);
        crd = 1'b0;
        chk("wr_count_4", 32'(wr_count), 32'd4);

        // Completion and dump.
        busy = 1'b0; dump_sel = 3'd1; dump_addr = 12'd7;
        step();
        chk("done_rise", 32'(done), 32'd1);
        step();
        chk("dump_bank1", 32'(dump_data), 32'h00011);
        chk("wr_count_after", 32'(wr_count), 32'd4);
        chk("err_sticky", 32'(err), 32'd1);
        dump_sel = 3'd4; dump_addr = 12'd1024;
        step();
        chk("dump_oob_zero", 32'(dump_data), 32'd0);

        // Second run, then reset mid-run.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run2_ready", 32'(ready), 32'd1);
        chk("run2_done_clr", 32'(done), 32'd0);
        chk("run2_err_clr", 32'(err), 32'd0);
        chk("run2_cnt_clr", 32'(wr_count), 32'd0);
        busy = 1'b1;
        step();
        cwr = 1'b1; csel = 3'd7;
        step();
        cwr = 1'b0;
        chk("run2_err_badsel", 32'(err), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_cdata", 32'(cdata_rd), 32'd0);
        step();
        reset = 1'b0; busy = 1'b0; dump_sel = 3'd1; dump_addr = 12'd7;
        step();
        chk("dump_retained", 32'(dump_data), 32'h00011);
        chk("ready_after_rst", 32'(ready), 32'd0);

        // Layer access outside RUN is serviced but flagged.
        cwr = 1'b1; csel = 3'd2; caddr_wr = 12'd0; cdata_wr = 20'h00033;
        step();
        cwr = 1'b0;
        chk("idle_wr_err", 32'(err), 32'd1);
        chk("idle_wr_count", 32'(wr_count), 32'd1);
        crd = 1'b1; caddr_rd = 12'd0;
        step();
        crd = 1'b0;
        chk("idle_rd_bank2", 32'(cdata_rd), 32'h00033);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
